// File: rtl/datapath_pipe.sv
// datapath_pipe -- two-stage pipelined register-file datapath.
//
// ISSUE stage: reads operand A, register B and the post-mux operand B. Both
// register reads are forwarded from the EX stage when the EX instruction is
// about to write the same register. EX stage: the function unit works on the
// latched operands. The write-back mux picks the ALU result or the data_in
// sampled at issue. The register file and the V/C/N/Z flags update on the
// edge that ends EX, so a dependent instruction can issue on the very next
// cycle without stalling.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   issue_valid              instruction presented this cycle
//   dest_sel/A_sel/B_sel     destination and operand register selects
//   op_sel                   function code (0..15)
//   const_in, const_sel      constant operand and operand-B mux select
//   data_in, data_sel        external load data and write-back mux select
//   load_en, flag_en         write destination / update flags at end of EX
//   A_OUT, B_OUT, AROUND     latched operand A, register B, post-mux B (EX)
//   wb_valid, wb_data        EX valid and the value being written back
//   V, C, N, Z               registered status flags
module datapath_pipe #(
    parameter int WIDTH = 16,
    parameter int REGS  = 16,
    parameter int RSEL  = $clog2(REGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    input  logic [RSEL-1:0]  dest_sel,
    input  logic [RSEL-1:0]  A_sel,
    input  logic [RSEL-1:0]  B_sel,
    input  logic [3:0]       op_sel,
    input  logic [WIDTH-1:0] const_in,
    input  logic             const_sel,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_sel,
    input  logic             load_en,
    input  logic             flag_en,
    output logic [WIDTH-1:0] A_OUT,
    output logic [WIDTH-1:0] B_OUT,
    output logic [WIDTH-1:0] AROUND,
    output logic             wb_valid,
    output logic [WIDTH-1:0] wb_data,
    output logic             V,
    output logic             C,
    output logic             N,
    output logic             Z
);

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             c;
        logic             v;
    } add_t;

    // Shared adder for ops 1-6: carry-out and two's-complement overflow.
    function automatic add_t add_flags(input logic [WIDTH-1:0] x,
                                       input logic [WIDTH-1:0] y,
                                       input logic             ci);
        logic [WIDTH:0] s;
        add_t           r;
        s     = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
        r.sum = s[WIDTH-1:0];
        r.c   = s[WIDTH];
        r.v   = (x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
        return r;
    endfunction

    logic [WIDTH-1:0] rf [REGS];

    logic             vld_p1;
    logic [WIDTH-1:0] a_p1;
    logic [WIDTH-1:0] b_p1;
    logic [WIDTH-1:0] bm_p1;
    logic [WIDTH-1:0] data_p1;
    logic             dsel_p1;
    logic [RSEL-1:0]  dest_p1;
    logic             load_p1;
    logic             flag_p1;
    logic [3:0]       op_p1;
    logic             cin_p1;

    logic             fwd_a;
    logic             fwd_b;
    logic [WIDTH-1:0] a_p0;
    logic [WIDTH-1:0] b_p0;
    logic [WIDTH-1:0] bm_p0;
    logic             cin_p0;

    logic [WIDTH-1:0]        add_y;
    logic                    add_ci;
    add_t                    add_r;
    logic [WIDTH-1:0]        res;
    logic                    c_fu;
    logic                    v_fu;
    logic signed [WIDTH-1:0] bs_p1;

    // ---- stage p0: ISSUE (register read with forwarding) ----
    assign fwd_a  = vld_p1 && load_p1 && (dest_p1 == A_sel);
    assign fwd_b  = vld_p1 && load_p1 && (dest_p1 == B_sel);
    assign a_p0   = fwd_a ? wb_data : rf[A_sel];
    assign b_p0   = fwd_b ? wb_data : rf[B_sel];
    assign bm_p0  = const_sel ? const_in : b_p0;
    // The C register only catches up with the EX instruction at the edge that
    // issues this one, so take the EX carry directly when it is about to land.
    assign cin_p0 = (vld_p1 && flag_p1) ? c_fu : C;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            a_p1    <= '0;
            b_p1    <= '0;
            bm_p1   <= '0;
            data_p1 <= '0;
            dsel_p1 <= 1'b0;
            dest_p1 <= '0;
            load_p1 <= 1'b0;
            flag_p1 <= 1'b0;
            op_p1   <= '0;
            cin_p1  <= 1'b0;
        end else begin
            vld_p1 <= issue_valid;
            if (issue_valid) begin
                a_p1    <= a_p0;
                b_p1    <= b_p0;
                bm_p1   <= bm_p0;
                data_p1 <= data_in;
                dsel_p1 <= data_sel;
                dest_p1 <= dest_sel;
                load_p1 <= load_en;
                flag_p1 <= flag_en;
                op_p1   <= op_sel;
                cin_p1  <= cin_p0;
            end
        end
    end

    // ---- stage p1: EX (function unit, write-back mux) ----
    always_comb begin
        add_y  = '0;
        add_ci = 1'b0;
        case (op_p1)
            4'd1:    add_ci = 1'b1;
            4'd2:    add_y  = bm_p1;
            4'd3:    begin add_y = bm_p1;  add_ci = cin_p1; end
            4'd4:    begin add_y = ~bm_p1; add_ci = 1'b1;   end
            4'd5:    begin add_y = ~bm_p1; add_ci = cin_p1; end
            4'd6:    add_y  = '1;
            default: ;
        endcase
    end

    assign add_r = add_flags(a_p1, add_y, add_ci);
    assign bs_p1 = bm_p1;

    always_comb begin
        res  = '0;
        c_fu = 1'b0;
        v_fu = 1'b0;
        case (op_p1)
            4'd0:  res = a_p1;
            4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6: begin
                res  = add_r.sum;
                c_fu = add_r.c;
                v_fu = add_r.v;
            end
            4'd7:  res = a_p1 & bm_p1;
            4'd8:  res = a_p1 | bm_p1;
            4'd9:  res = a_p1 ^ bm_p1;
            4'd10: res = ~a_p1;
            4'd11: res = bm_p1;
            4'd12: begin res = {bm_p1[WIDTH-2:0], 1'b0}; c_fu = bm_p1[WIDTH-1]; end
            4'd13: begin res = {1'b0, bm_p1[WIDTH-1:1]}; c_fu = bm_p1[0]; end
            4'd14: begin res = bs_p1 >>> 1;              c_fu = bm_p1[0]; end
            default: res = a_p1 * bm_p1;
        endcase
    end

    assign wb_data  = dsel_p1 ? data_p1 : res;
    assign wb_valid = vld_p1;
    assign A_OUT    = a_p1;
    assign B_OUT    = b_p1;
    assign AROUND   = bm_p1;

    // ---- end of EX: architectural state update ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REGS; i++) rf[i] <= '0;
        end else if (vld_p1 && load_p1) begin
            rf[dest_p1] <= wb_data;
        end
    end

    // Flags follow the function-unit result even when data_in is written back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            V <= 1'b0;
            C <= 1'b0;
            N <= 1'b0;
            Z <= 1'b0;
        end else if (vld_p1 && flag_p1) begin
            V <= v_fu;
            C <= c_fu;
            N <= res[WIDTH-1];
            Z <= (res == '0);
        end
    end

endmodule

// File: tb/tb_datapath_pipe.sv
// Bench for datapath_pipe: a 16-bit/16-register instance and an
// 8-bit/4-register instance share one stimulus stream. An architectural
// model executes each instruction in program order with plain integer
// arithmetic; the pipelined DUTs must match it one edge after issue.
module tb_datapath_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        t_iv = 1'b0;
    logic [3:0]  t_dest = '0, t_a = '0, t_b = '0, t_op = '0;
    logic [15:0] t_const = '0, t_din = '0;
    logic        t_csel = 1'b0, t_dsel = 1'b0, t_ld = 1'b0, t_fe = 1'b0;

    logic [15:0] a16, b16, ar16, wb16;
    logic        wv16, v16, c16, n16, z16;
    logic [7:0]  a8, b8, ar8, wb8;
    logic        wv8, v8, c8, n8, z8;

    int checks = 0;
    int errors = 0;

    // Model state: index 0 = 16-bit instance, 1 = 8-bit instance.
    longint     mr [2][16];
    logic [3:0] mf [2];                 // {V,C,N,Z}
    logic [3:0] exf [2];
    longint     exa [2], exb [2], exar [2], exwb [2];

    always #5 clk = ~clk;

    datapath_pipe #(.WIDTH(16), .REGS(16)) dut16 (
        .clk(clk), .rst(rst), .issue_valid(t_iv),
        .dest_sel(t_dest), .A_sel(t_a), .B_sel(t_b), .op_sel(t_op),
        .const_in(t_const), .const_sel(t_csel),
        .data_in(t_din), .data_sel(t_dsel),
        .load_en(t_ld), .flag_en(t_fe),
        .A_OUT(a16), .B_OUT(b16), .AROUND(ar16),
        .wb_valid(wv16), .wb_data(wb16),
        .V(v16), .C(c16), .N(n16), .Z(z16)
    );

    datapath_pipe #(.WIDTH(8), .REGS(4)) dut8 (
        .clk(clk), .rst(rst), .issue_valid(t_iv),
        .dest_sel(t_dest[1:0]), .A_sel(t_a[1:0]), .B_sel(t_b[1:0]), .op_sel(t_op),
        .const_in(t_const[7:0]), .const_sel(t_csel),
        .data_in(t_din[7:0]), .data_sel(t_dsel),
        .load_en(t_ld), .flag_en(t_fe),
        .A_OUT(a8), .B_OUT(b8), .AROUND(ar8),
        .wb_valid(wv8), .wb_data(wb8),
        .V(v8), .C(c8), .N(n8), .Z(z8)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 16; i++) mr[k][i] = 0;
            mf[k] = 4'b0000;
        end
    endtask

    // Executes the currently driven instruction on the architectural model.
    task automatic model_issue(input int k);
        int     w, nr, rd, ra, rb;
        longint m, hb, a, b, bm, r, sa, sb, ideal, ci, wv;
        logic   c, v, n, z;
        w  = (k == 0) ? 16 : 8;
        nr = (k == 0) ? 16 : 4;
        m  = (longint'(1) << w) - 1;
        hb = longint'(1) << (w - 1);
        rd = int'(t_dest) % nr;
        ra = int'(t_a) % nr;
        rb = int'(t_b) % nr;
        a  = mr[k][ra];
        b  = mr[k][rb];
        bm = t_csel ? (longint'(t_const) & m) : b;
        sa = (a >= hb) ? a - 2 * hb : a;
        sb = (bm >= hb) ? bm - 2 * hb : bm;
        ci = mf[k][2] ? 1 : 0;
        c = 1'b0; v = 1'b0; ideal = 0; r = 0;
        case (t_op)
            4'd0:  r = a;
            4'd1:  begin r = a + 1;       c = (r > m);            ideal = sa + 1; end
            4'd2:  begin r = a + bm;      c = (r > m);            ideal = sa + sb; end
            4'd3:  begin r = a + bm + ci; c = (r > m);            ideal = sa + sb + ci; end
            4'd4:  begin r = a - bm;      c = (a >= bm);          ideal = sa - sb; end
            4'd5:  begin r = a - bm - (1 - ci); c = (a >= bm + 1 - ci); ideal = sa - sb - (1 - ci); end
            4'd6:  begin r = a - 1;       c = (a >= 1);           ideal = sa - 1; end
            4'd7:  r = a & bm;
            4'd8:  r = a | bm;
            4'd9:  r = a ^ bm;
            4'd10: r = m - a;
            4'd11: r = bm;
            4'd12: begin r = bm * 2; c = (bm >= hb); end
            4'd13: begin r = bm / 2; c = (bm % 2 == 1); end
            4'd14: begin r = bm / 2 + ((bm >= hb) ? hb : 0); c = (bm % 2 == 1); end
            default: r = a * bm;
        endcase
        r = r & m;
        if (t_op >= 4'd1 && t_op <= 4'd6) v = (ideal < -hb) || (ideal >= hb);
        n  = (r >= hb);
        z  = (r == 0);
        wv = t_dsel ? (longint'(t_din) & m) : r;
        exa[k] = a; exb[k] = b; exar[k] = bm; exwb[k] = wv;
        if (t_ld) mr[k][rd] = wv;
        if (t_fe) mf[k] = {v, c, n, z};
    endtask

    task automatic check_ex(input logic v);
        chk("vld16", 32'(wv16), 32'(v));
        chk("vld8",  32'(wv8),  32'(v));
        chk("flg16", 32'({v16, c16, n16, z16}), 32'(exf[0]));
        chk("flg8",  32'({v8, c8, n8, z8}),     32'(exf[1]));
        if (v) begin
            chk("wb16", 32'(wb16), 32'(exwb[0]));
            chk("a16",  32'(a16),  32'(exa[0]));
            chk("b16",  32'(b16),  32'(exb[0]));
            chk("ar16", 32'(ar16), 32'(exar[0]));
            chk("wb8",  32'(wb8),  32'(exwb[1]));
            chk("a8",   32'(a8),   32'(exa[1]));
            chk("b8",   32'(b8),   32'(exb[1]));
            chk("ar8",  32'(ar8),  32'(exar[1]));
        end
    endtask

    task automatic step(input logic v, input logic [3:0] op, input logic [3:0] rd,
                        input logic [3:0] ra, input logic [3:0] rb,
                        input logic [15:0] cst, input logic cs,
                        input logic [15:0] din, input logic ds,
                        input logic ld, input logic fe);
        @(negedge clk);
        t_iv = v; t_op = op; t_dest = rd; t_a = ra; t_b = rb;
        t_const = cst; t_csel = cs; t_din = din; t_dsel = ds; t_ld = ld; t_fe = fe;
        for (int k = 0; k < 2; k++) begin
            exf[k] = mf[k];
            if (v) model_issue(k);
        end
        @(posedge clk);
        #1;
        check_ex(v);
    endtask

    task automatic bubble();
        step(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic load(input logic [3:0] rd, input logic [15:0] val);
        step(1'b1, 4'd0, rd, 4'd0, 4'd0, 16'h0, 1'b0, val, 1'b1, 1'b1, 1'b0);
    endtask

    function automatic logic [3:0] rsel();
        return ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_vld16", 32'(wv16), 32'h0);
        chk("rst_wb16",  32'(wb16), 32'h0);
        chk("rst_a16",   32'(a16),  32'h0);
        chk("rst_b16",   32'(b16),  32'h0);
        chk("rst_ar16",  32'(ar16), 32'h0);
        chk("rst_flg16", 32'({v16, c16, n16, z16}), 32'h0);
        chk("rst_vld8",  32'(wv8),  32'h0);
        chk("rst_flg8",  32'({v8, c8, n8, z8}), 32'h0);
        rst = 1'b0;

        // Constant add, then a dependent add forwarded on both operands.
        step(1'b1, 4'd2, 4'd1, 4'd0, 4'd0, 16'h0005, 1'b1, 16'h0, 1'b0, 1'b1, 1'b0);
        chk("cadd_ar16", 32'(ar16), 32'h0005);
        step(1'b1, 4'd2, 4'd2, 4'd1, 4'd1, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
        chk("cadd_wb16", 32'(wb16), 32'h000A);
        chk("cadd_wb8",  32'(wb8),  32'h0A);

        // Carry chain: FFFF+0001 then ADC r0+r0 with the forwarded carry.
        load(4'd1, 16'hFFFF);
        load(4'd2, 16'h0001);
        step(1'b1, 4'd2, 4'd3, 4'd1, 4'd2, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
        chk("cc_sum16", 32'(wb16), 32'h0000);
        step(1'b1, 4'd3, 4'd4, 4'd0, 4'd0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
        chk("cc_adc16", 32'(wb16), 32'h0001);
        chk("cc_flg16", 32'({v16, c16, n16, z16}), 32'b0101);

        // Signed overflow.
        load(4'd5, 16'h7FFF);
        step(1'b1, 4'd2, 4'd6, 4'd5, 4'd0, 16'h0001, 1'b1, 16'h0, 1'b0, 1'b1, 1'b1);
        chk("ovf_wb16", 32'(wb16), 32'h8000);
        bubble();
        chk("ovf_flg16", 32'({v16, c16, n16, z16}), 32'b1010);

        // External data load; flags untouched, register visible after a bubble.
        step(1'b1, 4'd9, 4'd7, 4'd5, 4'd5, 16'h0, 1'b0, 16'hBEEF, 1'b1, 1'b1, 1'b0);
        chk("ld_wb16", 32'(wb16), 32'hBEEF);
        bubble();
        step(1'b1, 4'd0, 4'd0, 4'd7, 4'd0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        chk("ld_r7", 32'(a16), 32'hBEEF);

        // Arithmetic shift right on the narrow instance.
        load(4'd1, 16'h0080);
        step(1'b1, 4'd14, 4'd2, 4'd0, 4'd1, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
        chk("asr_wb8", 32'(wb8), 32'hC0);
        bubble();
        chk("asr_flg8", 32'({v8, c8, n8, z8}), 32'b0010);

        // Randomized instruction stream with bubbles.
        for (int i = 0; i < 400; i++) begin
            step(logic'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                 rsel(), rsel(), rsel(), 16'($urandom), logic'($urandom_range(0, 1)),
                 16'($urandom), logic'($urandom_range(0, 3) == 0),
                 logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 1)));
        end

        // Reset while a write to r3 is in EX.
        @(negedge clk);
        t_iv = 1'b1; t_op = 4'd11; t_dest = 4'd3; t_a = 4'd0; t_b = 4'd0;
        t_const = 16'h1234; t_csel = 1'b1; t_dsel = 1'b0; t_ld = 1'b1; t_fe = 1'b1;
        @(posedge clk);
        #2;
        chk("mid_pre_vld16", 32'(wv16), 32'h1);
        rst = 1'b1;
        #1;
        chk("mid_vld16", 32'(wv16), 32'h0);
        chk("mid_wb16",  32'(wb16), 32'h0);
        chk("mid_flg16", 32'({v16, c16, n16, z16}), 32'h0);
        @(negedge clk);
        t_iv = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        step(1'b1, 4'd0, 4'd0, 4'd3, 4'd3, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        chk("mid_r3", 32'(a16), 32'h0);
        bubble();
        chk("mid_flg_after", 32'({v16, c16, n16, z16}), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
